abs_argmax_fp32_stream: RTL and testbench

// - Streaming abs-argmax: consumes one frame of fp_32_t correlation values over valid/ready,

---
 rtl/abs_argmax_fp32_stream_pkg.sv | 15 +
 rtl/abs_argmax_fp32_stream_abs_sat.sv | 19 +
 rtl/abs_argmax_fp32_stream.sv | 129 ++++++++++++
 tb/tb_abs_argmax_fp32_stream.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/abs_argmax_fp32_stream_pkg.sv
// Shared definitions for the abs-argmax stream stage: fp_32_t limits and FSM states.
package abs_argmax_fp32_stream_pkg;

    typedef logic [31:0] fp_32_t;

    localparam fp_32_t FP32_MAX = 32'h7FFF_FFFF;
    localparam fp_32_t FP32_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } argmax_state_e;

endpackage

// File: rtl/abs_argmax_fp32_stream_abs_sat.sv
// Combinational saturating magnitude of a signed fp_32_t; the most negative code maps to FP32_MAX.
module abs_sat_fp32
    import abs_argmax_fp32_stream_pkg::*;
(
    input  fp_32_t value_i,
    output fp_32_t abs_o
);

    always_comb begin
        if (value_i == FP32_MIN) begin
            abs_o = FP32_MAX;
        end else if (value_i[31]) begin
            abs_o = ~value_i + 32'd1;
        end else begin
            abs_o = value_i;
        end
    end

endmodule

// File: rtl/abs_argmax_fp32_stream.sv
// Frame-delimited streaming abs-argmax: reports the first position of the largest |value|,
// the beat count and an overflow flag once per frame, with a held, back-pressurable result.
module abs_argmax_fp32_stream
    import abs_argmax_fp32_stream_pkg::*;
#(
    parameter  int MAX_LEN = 1024,
    localparam int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             in_valid,
    output logic             in_ready,
    input  fp_32_t           in_value,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output fp_32_t           out_max,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W:0]   out_len,
    output logic             out_overflow
);

    localparam logic [IDX_W:0] LEN_CAP = (IDX_W + 1)'(MAX_LEN);

    argmax_state_e    state_q, state_d;
    logic [IDX_W:0]   count_q, count_d;
    fp_32_t           best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             ovf_q, ovf_d;

    fp_32_t           out_max_q;
    logic [IDX_W-1:0] out_index_q;
    logic [IDX_W:0]   out_len_q;
    logic             out_ovf_q;

    fp_32_t           abs_val;
    logic             accept;
    logic             first_beat;

    abs_sat_fp32 u_abs (
        .value_i (in_value),
        .abs_o   (abs_val)
    );

    assign out_valid = (state_q == DONE);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    // Outside ACCUM any accepted beat opens a new frame (IDLE, or DONE being drained).
    assign first_beat = (state_q != ACCUM);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = in_last ? DONE : ACCUM;
            end
            ACCUM: begin
                if (accept && in_last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) state_d = in_last ? DONE : ACCUM;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (first_beat) begin
                count_d    = {{IDX_W{1'b0}}, 1'b1};
                best_d     = abs_val;
                best_idx_d = '0;
                ovf_d      = 1'b0;
            end else if (count_q == LEN_CAP) begin
                // Past capacity: beats are swallowed uncompared, count stays saturated.
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
                if (abs_val > best_q) begin
                    best_d     = abs_val;
                    best_idx_d = count_q[IDX_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            count_q    <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            ovf_q      <= ovf_d;
        end
    end

    // Result bank loads only with the closing beat, so it is frozen while DONE waits.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            out_max_q   <= '0;
            out_index_q <= '0;
            out_len_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (accept && in_last) begin
            out_max_q   <= best_d;
            out_index_q <= best_idx_d;
            out_len_q   <= count_d;
            out_ovf_q   <= ovf_d;
        end
    end

    assign out_max      = out_max_q;
    assign out_index    = out_index_q;
    assign out_len      = out_len_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_abs_argmax_fp32_stream.sv
// Bench for abs_argmax_fp32_stream: vector table, directed corner sequences, random frames vs model.
`timescale 1ns/1ps
module tb_abs_argmax_fp32_stream;

    localparam int TB_LEN = 8;
    localparam int IW     = $clog2(TB_LEN);

    logic          clock = 1'b0;
    logic          resetN;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_value;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_max;
    logic [IW-1:0] out_index;
    logic [IW:0]   out_len;
    logic          out_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    abs_argmax_fp32_stream #(.MAX_LEN(TB_LEN)) dut (
        .clock        (clock),
        .resetN       (resetN),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_value     (in_value),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_max      (out_max),
        .out_index    (out_index),
        .out_len      (out_len),
        .out_overflow (out_overflow)
    );

    typedef struct {
        int          start;
        int          n;
        logic [31:0] emax;
        int          eidx;
        int          elen;
        logic        eovf;
    } vec_t;

    typedef struct {
        logic [31:0] mx;
        int          idx;
        int          len;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] v;
        logic        last;
    } beat_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // One clock cycle: apply inputs just after the edge, sample once they have settled.
    task automatic drive(input logic iv, input logic [31:0] v, input logic il, input logic ordy,
                         output logic acc, output logic hs);
        @(posedge clock);
        #1;
        in_valid  = iv;
        in_value  = v;
        in_last   = il;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
    endtask

    function automatic longint ref_abs(input logic [31:0] x);
        longint s;
        s = longint'($signed(x));
        if (s < 0) s = -s;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        return s;
    endfunction

    function automatic res_t ref_frame(input logic [31:0] f[$]);
        res_t   r;
        longint best;
        int     n;
        n     = f.size();
        best  = -1;
        r.len = (n > TB_LEN) ? TB_LEN : n;
        r.ovf = (n > TB_LEN);
        r.idx = 0;
        r.mx  = '0;
        for (int i = 0; i < r.len; i++) begin
            if (ref_abs(f[i]) > best) begin
                best  = ref_abs(f[i]);
                r.idx = i;
            end
        end
        r.mx = best[31:0];
        return r;
    endfunction

    logic [31:0] pool [33];
    vec_t        tbl  [9];
    beat_t       beats[$];
    res_t        exp_q[$];

    initial begin
        logic acc, hs, ok;
        logic [31:0] frame[$];
        res_t e;
        int cyc;

        pool = '{32'd3, -32'sd7, 32'd5, -32'sd7,
                 32'h8000_0000,
                 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10,
                 32'd5,
                 -32'sd2, -32'sd2, 32'd2,
                 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8,
                 32'd0, 32'd0,
                 32'h7FFF_FFFF, 32'h8000_0000,
                 -32'sd1, 32'h8000_0001};
        tbl = '{'{0,  4, 32'd7,          1, 4, 1'b0},
                '{4,  1, 32'h7FFF_FFFF,  0, 1, 1'b0},
                '{5,  10, 32'd8,         7, 8, 1'b1},
                '{15, 1, 32'd5,          0, 1, 1'b0},
                '{16, 3, 32'd2,          0, 3, 1'b0},
                '{19, 8, 32'd8,          7, 8, 1'b0},
                '{27, 2, 32'd0,          0, 2, 1'b0},
                '{29, 2, 32'h7FFF_FFFF,  0, 2, 1'b0},
                '{31, 2, 32'h7FFF_FFFF,  1, 2, 1'b0}};

        resetN = 1'b0; in_valid = 1'b0; in_value = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_max", out_max, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_out_overflow", out_overflow, 0);
        resetN = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 9; i++) begin
            ok = 1'b1;
            for (int b = 0; b < tbl[i].n; b++) begin
                drive(1'b1, pool[tbl[i].start + b], b == tbl[i].n - 1, 1'b1, acc, hs);
                if (!acc) ok = 1'b0;
            end
            chk($sformatf("v%0d_early_valid", i), out_valid, 0);
            chk($sformatf("v%0d_in_ready", i), ok, 1);
            drive(1'b0, '0, 1'b0, 1'b0, acc, hs);
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_out_max", i), out_max, tbl[i].emax);
            chk($sformatf("v%0d_out_index", i), out_index, tbl[i].eidx);
            chk($sformatf("v%0d_out_len", i), out_len, tbl[i].elen);
            chk($sformatf("v%0d_out_overflow", i), out_overflow, tbl[i].eovf);
            drive(1'b0, '0, 1'b0, 1'b1, acc, hs);
        end

        // Back-pressure hold, then a zero-bubble handover to the next frame.
        drive(1'b1, 32'd4, 1'b1, 1'b1, acc, hs);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'd11, 1'b0, 1'b0, acc, hs);
            chk("bp_in_ready", acc, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_max", out_max, 4);
        end
        drive(1'b1, 32'd9, 1'b1, 1'b1, acc, hs);
        chk("bp_accept_new", acc, 1);
        chk("bp_handshake", hs, 1);
        drive(1'b0, '0, 1'b0, 1'b0, acc, hs);
        chk("nb_out_valid", out_valid, 1);
        chk("nb_out_max", out_max, 9);
        chk("nb_out_index", out_index, 0);
        chk("nb_out_len", out_len, 1);
        drive(1'b0, '0, 1'b0, 1'b1, acc, hs);

        // Reset mid-frame discards the partial frame.
        drive(1'b1, 32'd100, 1'b0, 1'b1, acc, hs);
        drive(1'b1, 32'd200, 1'b0, 1'b1, acc, hs);
        @(posedge clock);
        #1;
        resetN = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_max", out_max, 0);
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;
        drive(1'b1, 32'd1, 1'b1, 1'b1, acc, hs);
        chk("post_rst_accept", acc, 1);
        drive(1'b0, '0, 1'b0, 1'b0, acc, hs);
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_out_max", out_max, 1);
        chk("post_rst_out_index", out_index, 0);
        chk("post_rst_out_len", out_len, 1);
        chk("post_rst_out_overflow", out_overflow, 0);
        drive(1'b0, '0, 1'b0, 1'b1, acc, hs);

        // Random frames with valid/ready gaps against the reference model.
        for (int f = 0; f < 1000; f++) begin
            int n;
            n = $urandom_range(1, 12);
            frame.delete();
            for (int b = 0; b < n; b++) begin
                logic [31:0] v;
                case ($urandom_range(0, 9))
                    0:       v = 32'h8000_0000;
                    1:       v = 32'h7FFF_FFFF;
                    2, 3:    v = 32'($signed($urandom_range(0, 6)) - 3);
                    default: v = $urandom;
                endcase
                frame.push_back(v);
                beats.push_back('{v, b == n - 1});
            end
            exp_q.push_back(ref_frame(frame));
        end

        cyc = 0;
        while ((beats.size() > 0 || exp_q.size() > 0) && cyc < 50000) begin
            logic iv, il, ordy;
            logic [31:0] v;
            iv   = (beats.size() > 0) && ($urandom_range(0, 3) != 0);
            v    = iv ? beats[0].v : $urandom;
            il   = iv ? beats[0].last : 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 9) < 7);
            drive(iv, v, il, ordy, acc, hs);
            if (acc) void'(beats.pop_front());
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_out_max", out_max, e.mx);
                    chk("rnd_out_index", out_index, e.idx);
                    chk("rnd_out_len", out_len, e.len);
                    chk("rnd_out_overflow", out_overflow, e.ovf);
                end
            end
            cyc++;
        end
        chk("rnd_cycle_budget", cyc < 50000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
